// File: rtl/signed_search_engine_pkg.sv
// Shared defaults and state encoding for the signed binary-search engine.
package signed_search_engine_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_CMP,
        S_DONE
    } state_t;
endpackage

// File: rtl/signed_search_engine_if.sv
// Request/result, table-read and comparator signals of the search engine.
interface signed_search_engine_if
    import signed_search_engine_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_key;
    logic [ADDR_W:0]   req_len;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] cmp_a;
    logic [DATA_W-1:0] cmp_b;
    logic              cmp_eq;
    logic              cmp_lt;
    logic              cmp_gt;
    logic              res_valid;
    logic              res_ready;
    logic              res_found;
    logic [ADDR_W:0]   res_index;
    logic [ADDR_W+1:0] res_probes;

    // master is the engine; slave is the requester / RAM / comparator side
    modport master (
        input  req_valid, req_key, req_len, mem_rdata, cmp_eq, cmp_lt, cmp_gt, res_ready,
        output req_ready, mem_rd_en, mem_addr, cmp_a, cmp_b,
               res_valid, res_found, res_index, res_probes
    );
    modport slave (
        output req_valid, req_key, req_len, mem_rdata, cmp_eq, cmp_lt, cmp_gt, res_ready,
        input  req_ready, mem_rd_en, mem_addr, cmp_a, cmp_b,
               res_valid, res_found, res_index, res_probes
    );
endinterface

// File: rtl/signed_search_engine.sv
// Binary search over a signed-sorted table: one probe = READ, WAIT, CMP using an
// external comparator; returns found flag plus match index or insertion point.
module signed_search_engine
    import signed_search_engine_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input logic clk,
    input logic rst_n,
    signed_search_engine_if.master bus
);
    // two extra bits so hi=-1 and lo=2**ADDR_W are representable
    localparam int IW = ADDR_W + 2;

    state_t state, stateNext;

    logic signed [IW-1:0] lo, hi, midQ, mid, newLo, newHi;
    logic [DATA_W-1:0]    key, word;
    logic [IW-1:0]        probes;
    logic                 resFound;
    logic [ADDR_W:0]      resIndex;
    logic                 oneHot, exhausted;

    assign mid       = lo + ((hi - lo) >>> 1);
    assign oneHot    = $onehot({bus.cmp_eq, bus.cmp_lt, bus.cmp_gt});
    assign newLo     = bus.cmp_gt ? midQ + IW'(1) : lo;
    assign newHi     = bus.cmp_lt ? midQ - IW'(1) : hi;
    assign exhausted = newLo > newHi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            S_IDLE: if (bus.req_valid) stateNext = (bus.req_len == '0) ? S_DONE : S_READ;
            S_READ: stateNext = S_WAIT;
            S_WAIT: stateNext = S_CMP;
            S_CMP:  stateNext = (!oneHot || bus.cmp_eq || exhausted) ? S_DONE : S_READ;
            S_DONE: if (bus.res_ready) stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key      <= '0;
            word     <= '0;
            lo       <= '0;
            hi       <= '0;
            midQ     <= '0;
            probes   <= '0;
            resFound <= 1'b0;
            resIndex <= '0;
        end else begin
            unique case (state)
                S_IDLE: if (bus.req_valid) begin
                    key      <= bus.req_key;
                    lo       <= '0;
                    hi       <= $signed({1'b0, bus.req_len}) - IW'(1);
                    probes   <= '0;
                    resFound <= 1'b0;
                    resIndex <= '0;
                end
                S_READ: begin
                    midQ   <= mid;
                    probes <= probes + IW'(1);
                end
                S_WAIT: word <= bus.mem_rdata;
                S_CMP: begin
                    // malformed flags end the search as not-found at the current lo
                    if (!oneHot) begin
                        resIndex <= lo[ADDR_W:0];
                    end else if (bus.cmp_eq) begin
                        resFound <= 1'b1;
                        resIndex <= midQ[ADDR_W:0];
                    end else begin
                        lo       <= newLo;
                        hi       <= newHi;
                        resIndex <= newLo[ADDR_W:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.req_ready  = (state == S_IDLE);
        bus.mem_rd_en  = (state == S_READ);
        bus.mem_addr   = (state == S_READ) ? mid[ADDR_W-1:0] : '0;
        bus.cmp_a      = key;
        bus.cmp_b      = word;
        bus.res_valid  = (state == S_DONE);
        bus.res_found  = resFound;
        bus.res_index  = resIndex;
        bus.res_probes = probes;
    end
endmodule
